// File: rtl/ixc_capture_pkg.sv
// Shared types for the ixc_capture block: captured entry layout and pointer sizing.
package ixc_capture_pkg;

  localparam int CAP_WIDTH = 11;
  localparam int CAP_TS_W  = 16;

  typedef struct packed {
    logic [CAP_WIDTH-1:0] data;
    logic [CAP_TS_W-1:0]  stamp;
  } cap_entry_t;

  // One extra bit beyond the index so full and empty differ only in the MSB.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ixc_capture_fifo.sv
// Single-clock FIFO of captured entries with a registered head so the
// read outputs are clean after reset and hold while empty.
module ixc_capture_fifo
  import ixc_capture_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = cap_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;

  entry_t           mem_q [DEPTH];
  entry_t           head_q, head_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_d;
  logic             push_eff, pop_eff;

  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_eff  = pop & ~empty;
    push_eff = push & (~full | pop_eff);
    wptr_d   = wptr_q + PTR_W'(push_eff);
    rptr_d   = rptr_q + PTR_W'(pop_eff);
    count_d  = wptr_d - rptr_d;
    head_d   = head_q;
    // The next head is either already in memory or is the entry written this edge.
    if (count_d != '0) begin
      if (push_eff && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) head_d = din;
      else                                                 head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign head  = head_q;
  assign count = wptr_q - rptr_q;

endmodule

// File: rtl/ixc_capture_11.sv
// Timestamped capture of an observed 11-bit net into a small FIFO drained
// by a host valid/ready channel, with a sticky overflow flag.
module ixc_capture_11
  import ixc_capture_pkg::*;
#(
  parameter int WIDTH     = 11,
  parameter int DEPTH     = 4,
  parameter int TS_W      = 16,
  parameter bit ON_CHANGE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       R,
  input  logic                   arm,
  input  logic                   trig,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic [TS_W-1:0]        rd_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TS_W-1:0]  stamp;
  } entry_t;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             first_q, first_d;
  logic             ovf_q, ovf_d;
  logic             cap, push, pop, drop, full, empty;
  entry_t           wr_entry, head;

  always_comb begin
    cap      = arm & (trig | (ON_CHANGE & (first_q | (R != prev_q))));
    pop      = ~empty & rd_ready;
    push     = cap & (~full | pop);
    drop     = cap & full & ~pop;
    ts_d     = ts_q + TS_W'(1);
    prev_d   = R;
    // Any disarmed cycle re-primes the forced first capture.
    first_d  = ~arm;
    ovf_d    = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
    wr_entry.data  = R;
    wr_entry.stamp = ts_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      prev_q  <= '0;
      first_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      prev_q  <= prev_d;
      first_q <= first_d;
      ovf_q   <= ovf_d;
    end
  end

  ixc_capture_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign rd_valid = ~empty;
  assign rd_data  = head.data;
  assign rd_stamp = head.stamp;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ixc_capture_11.sv
// Scoreboarded bench for ixc_capture_11: a default instance plus a 4-bit
// timestamp instance for wrap and mid-run reset.
module tb_ixc_capture_11;

  typedef struct packed {
    logic [10:0] data;
    logic [15:0] stamp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arm, trig, rd_ready, ovf_clr, rd_valid, overflow;
  logic [10:0] R, rd_data;
  logic [15:0] rd_stamp;
  logic [2:0]  count;

  logic        b_rst, b_arm, b_trig, b_ready, b_clr, b_valid, b_ovf;
  logic [10:0] b_R, b_data;
  logic [3:0]  b_stamp;
  logic [2:0]  b_count;

  ixc_capture_11 dut (
    .clk(clk), .rst(rst), .R(R), .arm(arm), .trig(trig),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_stamp(rd_stamp), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  ixc_capture_11 #(.WIDTH(11), .DEPTH(4), .TS_W(4), .ON_CHANGE(1'b1)) dut2 (
    .clk(clk), .rst(b_rst), .R(b_R), .arm(b_arm), .trig(b_trig),
    .rd_valid(b_valid), .rd_ready(b_ready), .rd_data(b_data),
    .rd_stamp(b_stamp), .count(b_count), .overflow(b_ovf), .ovf_clr(b_clr)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  exp_t expq2[$];
  exp_t e1, e2;
  logic [15:0] ts_ref;
  logic [3:0]  ts_ref2;
  logic [15:0] s_first, s0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference cycle counts since reset release; stamps are read off these.
  always @(posedge clk) ts_ref  <= rst   ? 16'd0 : ts_ref + 16'd1;
  always @(posedge clk) ts_ref2 <= b_rst ? 4'd0  : ts_ref2 + 4'd1;

  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", rd_data);
      end else begin
        e1 = expq.pop_front();
        chk("pop_data", 32'(rd_data), 32'(e1.data));
        chk("pop_stamp", 32'(rd_stamp), 32'(e1.stamp));
      end
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_valid && b_ready) begin
      if (expq2.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop2_unexpected actual=%0h required=none", b_data);
      end else begin
        e2 = expq2.pop_front();
        chk("pop2_data", 32'(b_data), 32'(e2.data));
        chk("pop2_stamp", 32'(b_stamp), 32'(e2.stamp));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; arm = 0; trig = 0; rd_ready = 0; ovf_clr = 0; R = '0;
    b_rst = 1; b_arm = 0; b_trig = 0; b_ready = 0; b_clr = 0; b_R = '0;

    // 1: reset then idle
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_data", 32'(rd_data), 0);
    end
    rst = 0;
    R = 11'h155;
    for (int k = 0; k < 20 && ts_ref != 16'd5; k++) begin
      tick();
      chk("idle_valid", 32'(rd_valid), 0);
      chk("idle_data", 32'(rd_data), 0);
    end
    chk("ts_reached5", 32'(ts_ref), 5);

    // 2: first-arm capture at timestamp 5
    arm = 1;
    expq.push_back('{data: 11'h155, stamp: 16'd5});
    tick();
    chk("arm_valid", 32'(rd_valid), 1);
    chk("arm_data", 32'(rd_data), 32'h155);
    chk("arm_stamp", 32'(rd_stamp), 5);
    tick(); tick();
    chk("steady_count", 32'(count), 1);

    // 3: change capture with concurrent drain
    rd_ready = 1;
    s0 = ts_ref;
    R = 11'h001; expq.push_back('{data: 11'h001, stamp: s0});
    tick(); chk("t3_count_le2", 32'(count <= 3'd2), 1);
    R = 11'h002; expq.push_back('{data: 11'h002, stamp: s0 + 16'd1});
    tick(); chk("t3_count_le2", 32'(count <= 3'd2), 1);
    R = 11'h7FF; expq.push_back('{data: 11'h7FF, stamp: s0 + 16'd2});
    tick(); chk("t3_count_le2", 32'(count <= 3'd2), 1);
    for (int k = 0; k < 10 && rd_valid; k++) tick();
    chk("t3_drained", 32'(rd_valid), 0);
    chk("t3_queue_empty", 32'(expq.size()), 0);
    rd_ready = 0;

    // 4: overflow, clear, and drop coincident with clear
    for (int i = 0; i < 5; i++) begin
      R = 11'h100 + 11'(i);
      trig = 1;
      if (i == 0) s_first = ts_ref;
      if (i < 4) expq.push_back('{data: R, stamp: ts_ref});
      tick();
    end
    trig = 0;
    tick();
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head_data", 32'(rd_data), 32'h100);
    chk("ovf_head_stamp", 32'(rd_stamp), 32'(s_first));
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("ovf_cleared", 32'(overflow), 0);
    ovf_clr = 1; trig = 1; R = 11'h1AA; tick();
    ovf_clr = 0; trig = 0;
    chk("ovf_set_wins", 32'(overflow), 1);
    chk("ovf_count_kept", 32'(count), 4);
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("ovf_cleared2", 32'(overflow), 0);

    // 5: full with simultaneous push and pop
    R = 11'h0AB; trig = 1; rd_ready = 1;
    expq.push_back('{data: 11'h0AB, stamp: ts_ref});
    tick();
    trig = 0;
    chk("fullpp_count", 32'(count), 4);
    chk("fullpp_ovf", 32'(overflow), 0);
    for (int k = 0; k < 10 && rd_valid; k++) tick();
    chk("t5_drained", 32'(rd_valid), 0);
    chk("t5_queue_empty", 32'(expq.size()), 0);
    rd_ready = 0;

    // disarm stops capture; re-arm forces one capture
    arm = 0; R = 11'h222; tick(); tick();
    chk("disarm_count", 32'(count), 0);
    arm = 1;
    expq.push_back('{data: 11'h222, stamp: ts_ref});
    tick(); tick();
    chk("rearm_count", 32'(count), 1);
    rd_ready = 1; tick(); rd_ready = 0;
    chk("rearm_queue_empty", 32'(expq.size()), 0);
    chk("rearm_drained", 32'(rd_valid), 0);

    // 6: 4-bit timestamp wrap and mid-run reset on second instance
    b_rst = 0; b_R = 11'h003;
    for (int k = 0; k < 40 && ts_ref2 != 4'd15; k++) tick();
    chk("ts2_reached15", 32'(ts_ref2), 15);
    b_arm = 1; expq2.push_back('{data: 11'h003, stamp: 16'd15}); tick();
    b_trig = 1; expq2.push_back('{data: 11'h003, stamp: 16'd0}); tick();
    b_R = 11'h005; expq2.push_back('{data: 11'h005, stamp: 16'd1}); tick();
    b_trig = 0;
    tick();
    chk("wrap_count", 32'(b_count), 3);
    chk("wrap_head15", 32'(b_stamp), 15);
    b_ready = 1; tick(); b_ready = 0;
    chk("wrap_head0", 32'(b_stamp), 0);
    chk("wrap_count2", 32'(b_count), 2);
    b_trig = 1; b_R = 11'h006;
    expq2.push_back('{data: 11'h006, stamp: 16'(ts_ref2)});
    tick();
    b_trig = 0;
    chk("prerst_count", 32'(b_count), 3);
    b_rst = 1; b_arm = 0; b_ready = 1;
    expq2.delete();
    tick();
    chk("midrst_count", 32'(b_count), 0);
    chk("midrst_valid", 32'(b_valid), 0);
    chk("midrst_data", 32'(b_data), 0);
    b_rst = 0; tick();
    chk("postrst_valid", 32'(b_valid), 0);
    b_ready = 0;
    tick();
    chk("final_queue_empty", 32'(expq.size() + expq2.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
